// File: rtl/benes_route_sequencer.sv
// Route sequencer for the Benes RAM/module interconnect: per-direction switch tables
// and a command FSM that loads a route, streams a burst, then drains the network.
module benes_route_sequencer #(
  parameter int STAGE_NUM   = 9,
  parameter int SWITCH_NUM  = 16,
  parameter int CFG_DEPTH   = 16,
  parameter int NET_LATENCY = 4,
  parameter int BEAT_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_wr_en,
  input  logic                         cfg_wr_dir,
  input  logic [$clog2(CFG_DEPTH)-1:0] cfg_wr_idx,
  input  logic [$clog2(STAGE_NUM)-1:0] cfg_wr_stage,
  input  logic [SWITCH_NUM-1:0]        cfg_wr_data,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_dir,
  input  logic [$clog2(CFG_DEPTH)-1:0] cmd_idx,
  input  logic [BEAT_W-1:0]            cmd_beats,
  output logic [SWITCH_NUM-1:0]        o_module_select [0:STAGE_NUM-1],
  output logic [SWITCH_NUM-1:0]        o_slot_select   [0:STAGE_NUM-1],
  output logic                         o_beat_valid,
  output logic                         o_beat_dir,
  output logic                         o_busy,
  output logic                         o_done
);

  // state  | meaning
  // IDLE   | waiting for a route command (cmd_ready high)
  // LOAD   | copy table[dir][idx] into that direction's select register
  // STREAM | one beat per cycle until the burst counter expires
  // DRAIN  | wait out the interconnect latency, no beats
  // DONE   | one-cycle completion pulse

  localparam int IDX_W = $clog2(CFG_DEPTH);
  localparam int CNT_W = BEAT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q;
  logic [IDX_W-1:0]   idx_q;
  logic               beat_dir_q;
  logic               accept;
  logic               stage_ok;

  logic [SWITCH_NUM-1:0] r2m_tbl_q  [CFG_DEPTH][STAGE_NUM];
  logic [SWITCH_NUM-1:0] m2r_tbl_q  [CFG_DEPTH][STAGE_NUM];
  logic [SWITCH_NUM-1:0] mod_sel_q  [STAGE_NUM];
  logic [SWITCH_NUM-1:0] slot_sel_q [STAGE_NUM];

  assign accept   = cmd_valid && cmd_ready;
  assign stage_ok = int'(cfg_wr_stage) < STAGE_NUM;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A zero beat field means a full 2^BEAT_W burst; the extra counter bit carries it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_LOAD;
          cnt_d   = {(cmd_beats == '0), cmd_beats};
        end
      end
      S_LOAD: state_d = S_STREAM;
      S_STREAM: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = (NET_LATENCY == 0) ? S_DONE : S_DRAIN;
          cnt_d   = CNT_W'(NET_LATENCY);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready    = (state_q == S_IDLE) && !rst;
    o_beat_valid = (state_q == S_STREAM);
    o_busy       = (state_q != S_IDLE);
    o_done       = (state_q == S_DONE);
    o_beat_dir   = beat_dir_q;
  end

  // Tables are read with the pre-edge value, so a same-cycle write lands after the LOAD copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < CFG_DEPTH; e++) begin
        for (int s = 0; s < STAGE_NUM; s++) begin
          r2m_tbl_q[e][s] <= '0;
          m2r_tbl_q[e][s] <= '0;
        end
      end
      for (int s = 0; s < STAGE_NUM; s++) begin
        mod_sel_q[s]  <= '0;
        slot_sel_q[s] <= '0;
      end
      dir_q      <= 1'b0;
      idx_q      <= '0;
      beat_dir_q <= 1'b0;
    end else begin
      if (cfg_wr_en && stage_ok) begin
        if (cfg_wr_dir) m2r_tbl_q[cfg_wr_idx][cfg_wr_stage] <= cfg_wr_data;
        else            r2m_tbl_q[cfg_wr_idx][cfg_wr_stage] <= cfg_wr_data;
      end
      if (accept) begin
        dir_q <= cmd_dir;
        idx_q <= cmd_idx;
      end
      if (state_q == S_LOAD) begin
        beat_dir_q <= dir_q;
        for (int s = 0; s < STAGE_NUM; s++) begin
          if (dir_q) slot_sel_q[s] <= m2r_tbl_q[idx_q][s];
          else       mod_sel_q[s]  <= r2m_tbl_q[idx_q][s];
        end
      end
    end
  end

  always_comb begin
    for (int s = 0; s < STAGE_NUM; s++) begin
      o_module_select[s] = mod_sel_q[s];
      o_slot_select[s]   = slot_sel_q[s];
    end
  end

endmodule

// File: tb/tb_benes_route_sequencer.sv
// Self-checking bench for benes_route_sequencer: a table/timeline reference model
// predicts every control output and both select arrays cycle by cycle.
module tb_benes_route_sequencer;
  localparam int STAGE_NUM   = 9;
  localparam int SWITCH_NUM  = 16;
  localparam int CFG_DEPTH   = 16;
  localparam int NET_LATENCY = 4;
  localparam int BEAT_W      = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_wr_en = 1'b0;
  logic        cfg_wr_dir = 1'b0;
  logic [3:0]  cfg_wr_idx = '0;
  logic [3:0]  cfg_wr_stage = '0;
  logic [15:0] cfg_wr_data = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_dir = 1'b0;
  logic [3:0]  cmd_idx = '0;
  logic [7:0]  cmd_beats = '0;
  logic [15:0] o_module_select [0:STAGE_NUM-1];
  logic [15:0] o_slot_select   [0:STAGE_NUM-1];
  logic        o_beat_valid, o_beat_dir, o_busy, o_done;

  benes_route_sequencer #(
    .STAGE_NUM(STAGE_NUM), .SWITCH_NUM(SWITCH_NUM), .CFG_DEPTH(CFG_DEPTH),
    .NET_LATENCY(NET_LATENCY), .BEAT_W(BEAT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_dir(cfg_wr_dir), .cfg_wr_idx(cfg_wr_idx),
    .cfg_wr_stage(cfg_wr_stage), .cfg_wr_data(cfg_wr_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_idx(cmd_idx), .cmd_beats(cmd_beats),
    .o_module_select(o_module_select), .o_slot_select(o_slot_select),
    .o_beat_valid(o_beat_valid), .o_beat_dir(o_beat_dir),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] model_r2m [CFG_DEPTH][STAGE_NUM];
  logic [15:0] model_m2r [CFG_DEPTH][STAGE_NUM];
  logic [15:0] exp_mod  [STAGE_NUM];
  logic [15:0] exp_slot [STAGE_NUM];

  bit keep_valid = 1'b0;
  bit nxt_dir = 1'b0;
  int nxt_idx = 0;
  int nxt_beats = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int e = 0; e < CFG_DEPTH; e++)
      for (int s = 0; s < STAGE_NUM; s++) begin
        model_r2m[e][s] = '0;
        model_m2r[e][s] = '0;
      end
    for (int s = 0; s < STAGE_NUM; s++) begin
      exp_mod[s]  = '0;
      exp_slot[s] = '0;
    end
  endtask

  task automatic cfg_write(input bit d, input int idx, input int s, input logic [15:0] data);
    cfg_wr_en = 1'b1; cfg_wr_dir = d; cfg_wr_idx = idx[3:0];
    cfg_wr_stage = s[3:0]; cfg_wr_data = data;
    tick();
    cfg_wr_en = 1'b0;
    if (d) model_m2r[idx][s] = data;
    else   model_r2m[idx][s] = data;
  endtask

  // Issues one command in an IDLE cycle (k=0 is the accept cycle) and checks every cycle up
  // to the next ready cycle. Optionally presents one table write at offset wr_k.
  task automatic run_cmd(input bit dir, input int idx, input int beats_field,
                         input int wr_k, input bit wr_dir, input int wr_idx,
                         input int wr_stage, input logic [15:0] wr_data);
    int b, last, bad_s;
    bit exp_bv, exp_done, exp_busy, exp_rdy;
    logic [15:0] snap [STAGE_NUM];
    b    = (beats_field == 0) ? 256 : beats_field;
    last = 3 + b + NET_LATENCY;
    cmd_valid = 1'b1; cmd_dir = dir; cmd_idx = idx[3:0]; cmd_beats = beats_field[7:0];
    for (int k = 0; k <= last; k++) begin
      if (k == wr_k) begin
        cfg_wr_en = 1'b1; cfg_wr_dir = wr_dir; cfg_wr_idx = wr_idx[3:0];
        cfg_wr_stage = wr_stage[3:0]; cfg_wr_data = wr_data;
      end
      if (k == 1)
        for (int s = 0; s < STAGE_NUM; s++) snap[s] = dir ? model_m2r[idx][s] : model_r2m[idx][s];
      if (k == 2)
        for (int s = 0; s < STAGE_NUM; s++)
          if (dir) exp_slot[s] = snap[s]; else exp_mod[s] = snap[s];
      exp_bv   = (k >= 2) && (k <= 1 + b);
      exp_done = (k == 2 + b + NET_LATENCY);
      exp_busy = (k >= 1) && (k <= 2 + b + NET_LATENCY);
      exp_rdy  = (k == 0) || (k == last);
      vectors++;
      if (o_beat_valid !== exp_bv) begin
        miscompares++;
        $display("FAIL beat_valid k=%0d got %b want %b", k, o_beat_valid, exp_bv);
      end
      vectors++;
      if (o_done !== exp_done) begin
        miscompares++;
        $display("FAIL done k=%0d got %b want %b", k, o_done, exp_done);
      end
      vectors++;
      if (o_busy !== exp_busy) begin
        miscompares++;
        $display("FAIL busy k=%0d got %b want %b", k, o_busy, exp_busy);
      end
      vectors++;
      if (cmd_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL cmd_ready k=%0d got %b want %b", k, cmd_ready, exp_rdy);
      end
      if (exp_bv) begin
        vectors++;
        if (o_beat_dir !== dir) begin
          miscompares++;
          $display("FAIL beat_dir k=%0d got %b want %b", k, o_beat_dir, dir);
        end
      end
      bad_s = -1;
      for (int s = STAGE_NUM - 1; s >= 0; s--)
        if (o_module_select[s] !== exp_mod[s] || o_slot_select[s] !== exp_slot[s]) bad_s = s;
      vectors++;
      if (bad_s >= 0) begin
        miscompares++;
        $display("FAIL selects k=%0d stage %0d got mod %h slot %h want mod %h slot %h",
                 k, bad_s, o_module_select[bad_s], o_slot_select[bad_s],
                 exp_mod[bad_s], exp_slot[bad_s]);
      end
      if (k == last) break;
      tick();
      if (k == 0) begin
        if (keep_valid) begin
          cmd_dir = nxt_dir; cmd_idx = nxt_idx[3:0]; cmd_beats = nxt_beats[7:0];
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (cfg_wr_en) begin
        if (cfg_wr_dir) model_m2r[cfg_wr_idx][cfg_wr_stage] = cfg_wr_data;
        else            model_r2m[cfg_wr_idx][cfg_wr_stage] = cfg_wr_data;
        cfg_wr_en = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; cmd_valid = 1'b0; cfg_wr_en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      if (cmd_ready !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_beat_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_ctrl cyc=%0d got rdy%b busy%b done%b bv%b want all 0",
                 c, cmd_ready, o_busy, o_done, o_beat_valid);
      end
    end
    bad = 0;
    for (int s = 0; s < STAGE_NUM; s++)
      if (o_module_select[s] !== 16'h0 || o_slot_select[s] !== 16'h0) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL reset_selects got %0d nonzero stages want 0", bad);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (cmd_ready !== 1'b1 || o_busy !== 1'b0 || o_beat_dir !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset got rdy%b busy%b dir%b want rdy1 busy0 dir0",
               cmd_ready, o_busy, o_beat_dir);
    end
    model_clear();
  endtask

  task automatic test_load_apply();
    for (int s = 0; s < STAGE_NUM; s++) cfg_write(1'b0, 3, s, 16'hA5A0 + 16'(s));
    run_cmd(1'b0, 3, 4, -1, 1'b0, 0, 0, 16'h0);
  endtask

  task automatic test_max_burst();
    for (int s = 0; s < STAGE_NUM; s++) cfg_write(1'b0, 7, s, 16'($urandom));
    run_cmd(1'b0, 7, 0, -1, 1'b0, 0, 0, 16'h0);
  endtask

  task automatic test_write_hazard();
    for (int s = 0; s < STAGE_NUM; s++) cfg_write(1'b1, 1, s, 16'($urandom) & 16'h7FFF);
    run_cmd(1'b1, 1, 4, 3, 1'b1, 1, 0, 16'hFFFF);
    run_cmd(1'b1, 1, 4, 1, 1'b1, 1, 0, 16'h1234);
    run_cmd(1'b1, 1, 2, -1, 1'b0, 0, 0, 16'h0);
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < STAGE_NUM; s++) begin
      cfg_write(1'b0, 2, s, 16'($urandom));
      cfg_write(1'b1, 5, s, 16'($urandom));
    end
    keep_valid = 1'b1; nxt_dir = 1'b1; nxt_idx = 5; nxt_beats = 1;
    run_cmd(1'b0, 2, 1, -1, 1'b0, 0, 0, 16'h0);
    keep_valid = 1'b0;
    run_cmd(1'b1, 5, 1, -1, 1'b0, 0, 0, 16'h0);
  endtask

  task automatic test_random();
    int nw, b, wk;
    for (int i = 0; i < 8; i++) begin
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++)
        cfg_write(1'($urandom), $urandom_range(0, 15), $urandom_range(0, 8), 16'($urandom));
      b  = $urandom_range(1, 12);
      wk = $urandom_range(0, 8) - 1;
      run_cmd(1'($urandom), $urandom_range(0, 15), b, wk, 1'($urandom),
              $urandom_range(0, 15), $urandom_range(0, 8), 16'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    int bad, dones;
    for (int s = 0; s < STAGE_NUM; s++) cfg_write(1'b1, 4, s, 16'($urandom) | 16'h0001);
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_idx = 4'd4; cmd_beats = 8'd8;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    vectors++;
    if (o_beat_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_second_beat got %b want 1", o_beat_valid);
    end
    rst = 1'b1;
    tick();
    bad = 0;
    for (int s = 0; s < STAGE_NUM; s++)
      if (o_module_select[s] !== 16'h0 || o_slot_select[s] !== 16'h0) bad++;
    vectors++;
    if (o_beat_valid !== 1'b0 || o_busy !== 1'b0 || cmd_ready !== 1'b0 || bad != 0) begin
      miscompares++;
      $display("FAIL mid_reset got bv%b busy%b rdy%b nonzero_stages=%0d want 0 0 0 0",
               o_beat_valid, o_busy, cmd_ready, bad);
    end
    rst = 1'b0;
    model_clear();
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_done === 1'b1 || o_beat_valid === 1'b1) dones++;
      tick();
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL mid_no_done got %0d active cycles want 0", dones);
    end
    run_cmd(1'b1, 4, 3, -1, 1'b0, 0, 0, 16'h0);
    run_cmd(1'b0, 3, 2, -1, 1'b0, 0, 0, 16'h0);
  endtask

  initial begin
    test_reset();
    test_load_apply();
    test_max_burst();
    test_write_hazard();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
